// File: rtl/lsu_mem_ctrl.sv
// Load/store sequencer between the lane decoder and the single-port data BRAM.
// Serialises one access at a time, waits out the BRAM read latency and formats load data.
module lsu_mem_ctrl #(
    parameter int BRAM_ADDR_WIDTH = 12,
    parameter int READ_LATENCY    = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_we,
    input  logic [2:0]                 req_func3,
    input  logic [31:0]                req_addr,
    input  logic [31:0]                req_wdata,
    input  logic [3:0]                 req_byte_enb,
    output logic                       resp_valid,
    output logic [31:0]                resp_rdata,
    output logic                       resp_misaligned,
    output logic                       stall,
    output logic                       bram_en,
    output logic [3:0]                 bram_we,
    output logic [BRAM_ADDR_WIDTH-1:0] bram_addr,
    output logic [31:0]                bram_wdata,
    input  logic [31:0]                bram_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    localparam logic [1:0] CNT_INIT = 2'(READ_LATENCY - 1);

    state_t                     state, state_nx;
    logic                       we_q;
    logic [2:0]                 func3_q;
    logic [1:0]                 lane_q;
    logic [3:0]                 mask_q;
    logic                       mis_q;
    logic [BRAM_ADDR_WIDTH-1:0] addr_q;
    logic [31:0]                wdata_q;
    logic [1:0]                 cnt;
    logic [31:0]                rdata_q;
    logic                       req_mis;
    logic                       load_f3_ok;
    logic                       accept;
    logic [7:0]                 sel_byte;
    logic [15:0]                sel_half;
    logic [31:0]                load_fmt;
    logic                       unused_addr_bits;

    assign unused_addr_bits = ^req_addr[31:BRAM_ADDR_WIDTH+2];

    always_comb begin
        load_f3_ok = 1'b0;
        case (req_func3)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: load_f3_ok = 1'b1;
            default:                                load_f3_ok = 1'b0;
        endcase
    end

    // An undecodable load width is folded into the same reject path as a zero mask.
    assign req_mis = (req_byte_enb == 4'b0000) | (~req_we & ~load_f3_ok);
    assign accept  = req_valid & (state == S_IDLE);

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (req_valid) state_nx = req_mis ? S_RESP : S_ISSUE;
            S_ISSUE: state_nx = we_q ? S_IDLE : S_WAIT;
            S_WAIT:  if (cnt == '0) state_nx = S_RESP;
            S_RESP:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        sel_byte = bram_rdata[{lane_q, 3'b000} +: 8];
        sel_half = lane_q[1] ? bram_rdata[31:16] : bram_rdata[15:0];
        load_fmt = '0;
        case (func3_q)
            3'b000:  load_fmt = {{24{sel_byte[7]}}, sel_byte};
            3'b100:  load_fmt = {24'h000000, sel_byte};
            3'b001:  load_fmt = {{16{sel_half[15]}}, sel_half};
            3'b101:  load_fmt = {16'h0000, sel_half};
            3'b010:  load_fmt = bram_rdata;
            default: load_fmt = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q    <= 1'b0;
            func3_q <= '0;
            lane_q  <= '0;
            mask_q  <= '0;
            mis_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt     <= '0;
            rdata_q <= '0;
        end else begin
            if (accept) begin
                we_q    <= req_we;
                func3_q <= req_func3;
                lane_q  <= req_addr[1:0];
                mask_q  <= req_byte_enb;
                mis_q   <= req_mis;
                // Port address/data only move for accesses that reach ISSUE.
                if (!req_mis) begin
                    addr_q  <= req_addr[BRAM_ADDR_WIDTH+1:2];
                    wdata_q <= req_wdata;
                end
            end
            if (state == S_ISSUE && !we_q) cnt <= CNT_INIT;
            else if (state == S_WAIT && cnt != '0) cnt <= cnt - 2'd1;
            if (state == S_WAIT && cnt == '0) rdata_q <= load_fmt;
        end
    end

    assign req_ready       = (state == S_IDLE) & ~rst;
    assign resp_valid      = (state == S_RESP) | ((state == S_ISSUE) & we_q);
    assign resp_misaligned = (state == S_RESP) & mis_q;
    assign resp_rdata      = ((state == S_RESP) && !mis_q) ? rdata_q : '0;
    assign stall           = ~rst & (((state == S_IDLE) & req_valid) |
                                     ((state != S_IDLE) & ~resp_valid));
    assign bram_en         = (state == S_ISSUE);
    assign bram_we         = ((state == S_ISSUE) && we_q) ? mask_q : '0;
    assign bram_addr       = addr_q;
    assign bram_wdata      = wdata_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: two instances (read latency 1 and 3) share stimulus and are
// checked every cycle against a transaction-level model with a word-array memory.
module tb_lsu_mem_ctrl;

    localparam int RL [2] = '{1, 3};

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_we;
    logic [2:0]  req_func3;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_byte_enb;

    logic        rdy [2], rv [2], rmis [2], stl [2], ben [2];
    logic [31:0] rrd [2], bwd [2], brd [2];
    logic [3:0]  bwe [2];
    logic [11:0] bad [2];

    always #5 clk = ~clk;

    lsu_mem_ctrl #(.BRAM_ADDR_WIDTH(12), .READ_LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[0]),
        .req_we(req_we), .req_func3(req_func3), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_byte_enb(req_byte_enb),
        .resp_valid(rv[0]), .resp_rdata(rrd[0]), .resp_misaligned(rmis[0]),
        .stall(stl[0]), .bram_en(ben[0]), .bram_we(bwe[0]), .bram_addr(bad[0]),
        .bram_wdata(bwd[0]), .bram_rdata(brd[0])
    );

    lsu_mem_ctrl #(.BRAM_ADDR_WIDTH(12), .READ_LATENCY(3)) dut3 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[1]),
        .req_we(req_we), .req_func3(req_func3), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_byte_enb(req_byte_enb),
        .resp_valid(rv[1]), .resp_rdata(rrd[1]), .resp_misaligned(rmis[1]),
        .stall(stl[1]), .bram_en(ben[1]), .bram_we(bwe[1]), .bram_addr(bad[1]),
        .bram_wdata(bwd[1]), .bram_rdata(brd[1])
    );

    // BRAM environment: byte-write RAM, read data delayed by 1 or 3 cycles.
    logic [31:0] bmem [2][4096];
    logic [31:0] p1 [2], p2 [2], p3 [2];

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (ben[d]) begin
                for (int b = 0; b < 4; b++)
                    if (bwe[d][b]) bmem[d][bad[d]][8*b +: 8] <= bwd[d][8*b +: 8];
                p1[d] <= bmem[d][bad[d]];
            end
            p2[d] <= p1[d];
            p3[d] <= p2[d];
        end
    end
    assign brd[0] = p1[0];
    assign brd[1] = p3[1];

    // Model state
    int          cyc = 0;
    logic        pend [2] = '{1'b0, 1'b0};
    int          t_acc [2];
    logic        e_we, e_mis;
    logic [3:0]  e_mask;
    logic [11:0] e_widx;
    logic [31:0] e_wdata, e_rd;
    logic [31:0] mmem [4096];
    logic        lit_on = 1'b0;
    logic [31:0] lit_val = '0;
    int          n_vec = 0, n_mis = 0;

    function automatic logic [31:0] fmt(input logic [31:0] w, input logic [2:0] f3,
                                        input logic [1:0] k);
        logic [31:0] b, h;
        b = (w >> (8 * k)) & 32'hFF;
        h = (w >> (16 * k[1])) & 32'hFFFF;
        case (f3)
            3'b000:  return (b >= 32'd128) ? b - 32'd256 : b;
            3'b100:  return b;
            3'b001:  return (h >= 32'h8000) ? h - 32'h10000 : h;
            3'b101:  return h;
            3'b010:  return w;
            default: return 32'h0;
        endcase
    endfunction

    function automatic int lat_of(input int d);
        return (e_mis || e_we) ? 1 : 2 + RL[d];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pend[0] = 1'b0;
            pend[1] = 1'b0;
        end else begin
            logic was_busy;
            logic [31:0] bm;
            cyc++;
            was_busy = pend[0] | pend[1];
            for (int d = 0; d < 2; d++)
                if (pend[d] && (cyc - 1 - t_acc[d] == lat_of(d))) pend[d] = 1'b0;
            if (req_valid && !was_busy) begin
                e_we    = req_we;
                e_mask  = req_byte_enb;
                e_mis   = (req_byte_enb == 4'b0000) ||
                          (!req_we && !(req_func3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}));
                e_widx  = req_addr[13:2];
                e_wdata = req_wdata;
                e_rd    = '0;
                if (!e_mis && e_we) begin
                    bm = '0;
                    for (int b = 0; b < 4; b++) if (e_mask[b]) bm |= 32'hFF << (8 * b);
                    mmem[e_widx] = (mmem[e_widx] & ~bm) | (e_wdata & bm);
                end
                if (!e_mis && !e_we) e_rd = fmt(mmem[e_widx], req_func3, req_addr[1:0]);
                for (int d = 0; d < 2; d++) begin
                    pend[d]  = 1'b1;
                    t_acc[d] = cyc - 1;
                end
            end
        end
    end

    task automatic chk(input string nm, input int d, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s dut_rl%0d @cyc %0d: got %h, want %h", nm, RL[d], cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        int off, lat;
        logic x_rv, x_en;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                chk("rst_req_ready", d, 32'(rdy[d]), 0);
                chk("rst_stall", d, 32'(stl[d]), 0);
                chk("rst_resp_valid", d, 32'(rv[d]), 0);
                chk("rst_resp_mis", d, 32'(rmis[d]), 0);
                chk("rst_resp_rdata", d, rrd[d], 0);
                chk("rst_bram_en", d, 32'(ben[d]), 0);
                chk("rst_bram_we", d, 32'(bwe[d]), 0);
                chk("rst_bram_addr", d, 32'(bad[d]), 0);
                chk("rst_bram_wdata", d, bwd[d], 0);
            end else begin
                off  = cyc - t_acc[d];
                lat  = lat_of(d);
                x_rv = pend[d] && (off == lat);
                x_en = pend[d] && (off == 1) && !e_mis;
                chk("req_ready", d, 32'(rdy[d]), 32'(!pend[d]));
                chk("stall", d, 32'(stl[d]), 32'(pend[d] ? (off < lat) : req_valid));
                chk("resp_valid", d, 32'(rv[d]), 32'(x_rv));
                chk("resp_mis", d, 32'(rmis[d]), 32'(x_rv && e_mis));
                chk("resp_rdata", d, rrd[d], (x_rv && !e_mis && !e_we) ? e_rd : 32'h0);
                chk("bram_en", d, 32'(ben[d]), 32'(x_en));
                chk("bram_we", d, 32'(bwe[d]), (x_en && e_we) ? 32'(e_mask) : 32'h0);
                if (x_en) begin
                    chk("bram_addr", d, 32'(bad[d]), 32'(e_widx));
                    if (e_we) chk("bram_wdata", d, bwd[d], e_wdata);
                end
                if (x_rv && !e_mis && !e_we && lit_on) begin
                    chk("lit_rdata", d, rrd[d], lit_val);
                    chk("model_pin", d, e_rd, lit_val);
                end
            end
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 20 && (pend[0] || pend[1]); i++) @(negedge clk);
        if (pend[0] || pend[1]) begin
            $display("FAIL resp_timeout: model busy after 20 cycles, want idle");
            $fatal(1);
        end
    endtask

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] m,
                          input logic lon, input logic [31:0] lv);
        @(posedge clk); #1;
        lit_on = lon; lit_val = lv;
        req_we = we; req_func3 = f3; req_addr = a; req_wdata = wd; req_byte_enb = m;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        wait_idle();
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b1; req_we = 1'b0; req_func3 = '0;
        req_addr = '0; req_wdata = '0; req_byte_enb = '0;
        repeat (2) @(negedge clk);
        #2 req_valid = 1'b0;
        rst = 1'b0;
        repeat (2) @(negedge clk);

        do_req(1, 3'b010, 32'h0000_0010, 32'hDEADBEEF, 4'b1111, 0, 0);
        do_req(0, 3'b010, 32'h0000_0010, 0, 4'b1111, 1, 32'hDEADBEEF);
        do_req(1, 3'b010, 32'h0000_0000, 32'h80FF7F01, 4'b1111, 0, 0);
        do_req(0, 3'b000, 32'h0000_0003, 0, 4'b1000, 1, 32'hFFFFFF80);
        do_req(0, 3'b100, 32'h0000_0003, 0, 4'b1000, 1, 32'h00000080);
        do_req(0, 3'b000, 32'h0000_0001, 0, 4'b0010, 1, 32'h0000007F);
        do_req(0, 3'b001, 32'h0000_0002, 0, 4'b1100, 1, 32'hFFFF80FF);
        do_req(0, 3'b101, 32'h0000_0000, 0, 4'b0011, 1, 32'h00007F01);
        do_req(0, 3'b010, 32'h0000_0000, 0, 4'b1111, 1, 32'h80FF7F01);
        do_req(0, 3'b010, 32'h0000_0002, 0, 4'b0000, 0, 0);
        do_req(0, 3'b011, 32'h0000_0000, 0, 4'b1111, 0, 0);
        do_req(1, 3'b000, 32'h0000_4005, 32'h0000AB00, 4'b0010, 0, 0);
        do_req(0, 3'b100, 32'h0000_0005, 0, 4'b0010, 1, 32'h000000AB);
        do_req(1, 3'b001, 32'h0000_0006, 32'h12340000, 4'b1100, 0, 0);
        do_req(0, 3'b010, 32'h0000_0004, 0, 4'b1111, 1, 32'h1234AB00);
        do_req(1, 3'b000, 32'h0000_0001, 32'h0000CC00, 4'b0000, 0, 0);

        // Held request: a store, then the same request re-accepted once IDLE returns.
        @(posedge clk); #1;
        lit_on = 1'b0;
        req_we = 1'b1; req_func3 = 3'b010; req_addr = 32'h8; req_wdata = 32'h0BADF00D;
        req_byte_enb = 4'b1111; req_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1 req_valid = 1'b0;
        wait_idle();
        do_req(0, 3'b010, 32'h0000_0008, 0, 4'b1111, 1, 32'h0BADF00D);

        // Abort a load in WAIT.
        @(posedge clk); #1;
        req_we = 1'b0; req_func3 = 3'b010; req_addr = 32'h0; req_byte_enb = 4'b1111;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        @(negedge clk); #2;
        rst = 1'b0;
        repeat (8) @(negedge clk);
        do_req(0, 3'b010, 32'h0000_0000, 0, 4'b1111, 1, 32'h80FF7F01);
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Memory-access sequencer between the load/store lane decoder and the single-port data BRAM on the Zybo Z7-20.
- Accepts one load or store request at a time. Inputs are lane-aligned write data plus a byte-enable mask; a zero mask signals misalignment.
- Drives the BRAM port and waits out the configurable BRAM read latency.
- For loads, extracts and sign- or zero-extends the addressed byte or half-word.
- Holds a pipeline stall until the access completes.

Parameters:
- BRAM_ADDR_WIDTH, 12: word-address width of the data BRAM (4096 words).
- READ_LATENCY, 1: BRAM read latency in clock cycles after the bram_en cycle. Legal range is 1 to 3.

Ports:
- clk, input, 1: system clock; all state updates on its rising edge.
- rst, input, 1: asynchronous active-high reset.
- req_valid, input, 1: memory request present.
- req_ready, output, 1: block can accept a request; high only in IDLE.
- req_we, input, 1: 1 = store, 0 = load.
- req_func3, input, 3: RV32I funct3 of the load or store.
- req_addr, input, 32: byte address (ALU result).
- req_wdata, input, 32: store data, already shifted into its byte lanes.
- req_byte_enb, input, 4: lane mask from the decoder; 4'b0000 means misaligned or illegal.
- resp_valid, output, 1: one-cycle completion pulse.
- resp_rdata, output, 32: formatted load result. Valid while resp_valid is high for a load; 0 for stores and errors.
- resp_misaligned, output, 1: qualifies resp_valid; access was rejected.
- stall, output, 1: pipeline hold request.
- bram_en, output, 1: BRAM port enable.
- bram_we, output, 4: BRAM byte write enables.
- bram_addr, output, BRAM_ADDR_WIDTH: BRAM word address.
- bram_wdata, output, 32: BRAM write data.
- bram_rdata, input, 32: BRAM read data.

Behaviour:
- Reset: asynchronous on rst high. State returns to IDLE. All outputs are 0, latency counter is 0, captured request registers are 0. req_ready rises in the first cycle after rst falls.
- States:
  - IDLE: req_ready=1.
  - ISSUE: drives the BRAM.
  - WAIT: counts down the read latency.
  - RESP: pulses the load result.
- Accept: when req_valid and req_ready are both high at edge T, capture req_we, req_func3, req_addr[1:0], req_wdata, req_byte_enb, and word address req_addr[BRAM_ADDR_WIDTH+1:2]. Upper address bits are ignored, so addresses wrap modulo BRAM size.
- Misaligned (captured mask = 0): go from IDLE to RESP with no BRAM activity.
  - Cycle T+1: resp_valid=1, resp_misaligned=1, resp_rdata=0.
  - Then return to IDLE.
- Store: ISSUE in cycle T+1.
  - bram_en=1, bram_we=captured mask, bram_wdata=captured data.
  - resp_valid=1 in the same cycle, resp_misaligned=0.
  - Next state IDLE. Total store latency is 1 cycle.
- Load: ISSUE in cycle T+1 with bram_en=1 and bram_we=0.
  - Counter loads READ_LATENCY-1, next state WAIT.
  - WAIT decrements the counter. At the edge where the counter is 0, sample bram_rdata, format it into resp_rdata, and go to RESP.
  - RESP: resp_valid=1 in cycle T+2+READ_LATENCY, then IDLE.
- bram_en and bram_we are 0 in every state except ISSUE. bram_addr and bram_wdata hold their last values outside ISSUE.
- Load formatting uses lane k = captured addr[1:0]:
  - funct3 000 (LB): sign-extend byte k.
  - funct3 100 (LBU): zero-extend byte k.
  - funct3 001 (LH): sign-extend half k[1] (k = 0 or 2).
  - funct3 101 (LHU): zero-extend half k[1].
  - funct3 010 (LW): full word.
  - Any other funct3 with a nonzero mask: treated as misaligned.
- Between responses, resp_valid=0 and resp_misaligned=0. resp_rdata returns to 0 outside RESP.
- stall = (state==IDLE & req_valid) | (state!=IDLE & ~resp_valid). Stall drops in the response cycle so the pipeline advances on that edge.
- A request held on req_valid while the block is busy is not sampled. It is accepted in the next IDLE cycle.
- Back-to-back requests: after the response cycle the block is in IDLE, so the next request is accepted one cycle after resp_valid.
- Reset mid-operation: the FSM aborts immediately, bram_en and bram_we drop asynchronously, and no response is issued. A partially issued store may or may not land in the BRAM.

Test Plan:
- Store word: addr 0x0000_0010, mask 4'b1111, wdata 0xDEADBEEF. Required: in T+1, bram_en=1, bram_we=4'hF, bram_addr=4, resp_valid=1. Readback with LW returns 0xDEADBEEF.
- Byte load sign/zero: memory word 0x80FF7F01 at word 0. LB at addr 3 gives 0xFFFFFF80. LBU at addr 3 gives 0x00000080. LB at addr 1 gives 0x0000007F.
- Half load: same word. LH at addr 2 gives 0xFFFF80FF. LHU at addr 0 gives 0x00007F01.
- Latency sweep: READ_LATENCY=1 and 3, LW issued at T. Required: resp_valid exactly at T+3 and T+5 respectively. stall high from T through the cycle before resp_valid.
- Misaligned: LW at addr 0x2 with mask 0. Required: resp_valid=1 and resp_misaligned=1 at T+1, resp_rdata=0, bram_en never asserted.
- Reset mid-load: assert rst during WAIT. Required: bram_en, stall, resp_valid and req_ready drop to 0 asynchronously. After release, req_ready=1 and no stray resp_valid appears.
